lsq_ring: RTL and testbench
===========================

// Module: lsq_ring
// PURPOSE
//  Circular load/store queue, parametrised successor of the single-pointer LSQ. Entries allocated at
//  dispatch in program order; execute writes address/data; the head entry issues to data memory over a
//  valid/ready handshake once operands are ready, then dequeues. Supports wrap-around, full/empty,
//  simultaneous alloc/fill/issue, and whole-queue flush. Sits between dispatch/execute and the D-cache port.
// PARAMETERS
//  DEPTH      16  entries; power of two, >=2
//  PC_WIDTH   12  width of stored PC
//  ADDR_WIDTH 32  memory address width
//  DATA_WIDTH 32  store data width
//  IDX_W      $clog2(DEPTH)  entry index width (localparam)
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           async active-low reset
//  flush          in   1           sync: discard all entries
//  alloc_valid    in   1           dispatch requests an entry
//  alloc_opcode   in   7           LOAD_INSTR or STORE_INSTR
//  alloc_pc       in   PC_WIDTH    PC of instruction
//  alloc_ready    out  1           queue not full
//  alloc_idx      out  IDX_W       index granted (= tail) this cycle
//  ex_valid       in   1           execute delivers operands
//  ex_idx         in   IDX_W       target entry
//  ex_addr        in   ADDR_WIDTH  effective address
//  ex_data        in   DATA_WIDTH  store data (ignored for loads)
//  mem_valid      out  1           head entry presented to memory
//  mem_ready      in   1           memory accepts
//  mem_we         out  1           1 = store, 0 = load
//  mem_addr       out  ADDR_WIDTH  head address
//  mem_wdata      out  DATA_WIDTH  head store data
//  mem_pc         out  PC_WIDTH    head PC
//  mem_idx        out  IDX_W       head index
//  count          out  IDX_W+1     occupied entries
//  full, empty    out  1           count==DEPTH / count==0
// BEHAVIOUR
//  - Entry fields: valid, is_load, rdy, pc, addr, data. head, tail IDX_W bits, wrap mod DEPTH naturally.
//  - Reset (async, rst_n=0): head=tail=0, count=0, all valid/rdy=0; outputs: alloc_ready=1, alloc_idx=0,
//    mem_valid=0, mem_we=0, mem_addr/wdata/pc/idx=0, count=0, full=0, empty=1. Deassertion synchronous use.
//  - Alloc: fire = alloc_valid & alloc_ready. alloc_ready = ~full (combinational, no dependence on
//    same-cycle dequeue). On fire: entry[tail] <= {valid=1, is_load, rdy=0, pc}; tail <= tail+1.
//    is_load = (opcode==LOAD_INSTR); any other opcode with alloc_valid: alloc_ready still shown, no
//    allocation, assertion fires in sim.
//  - Fill: ex_valid writes addr/data, sets rdy=1 next edge. ex_valid to invalid entry: ignored, assertion.
//    Fill to the entry allocated same cycle is illegal (rdy cannot precede alloc).
//  - Issue: mem_valid = entry[head].valid & entry[head].rdy (combinational off registered state);
//    mem_* driven from entry[head], zero when mem_valid=0. In-order only; younger ready entries wait.
//  - Dequeue: deq = mem_valid & mem_ready -> entry[head].valid<=0, rdy<=0, head<=head+1.
//    mem_valid once high holds with stable payload until mem_ready (AXI-style).
//  - Count: count <= count + fire - deq; simultaneous fire and deq when full: fire blocked (ready low),
//    deq proceeds; when empty no deq. Count never exceeds DEPTH nor underflows.
//  - Fill of head and issue same cycle: issue sees old rdy=0; head issues next cycle (1-cycle latency
//    fill->mem_valid).
//  - Flush: highest priority over alloc/fill/deq; next edge head=tail=0, count=0, all valid=0.
//    mem_valid may be high in flush cycle; memory must treat a handshake in flush cycle as completed.
//  - Latency: alloc->earliest issue 2 cycles (alloc, fill, issue).
// STRUCTURE
//  - lsq_pkg: lsq_entry_t struct (valid,is_load,rdy,pc,addr,data), LOAD_INSTR/STORE_INSTR from
//    constants.v re-exported, IDX_W helper function.
//  - Entries as array of lsq_entry_t; one sequential always_ff (async reset), one always_comb for
//    outputs. No sub-module; pointer/count logic stays inline.
// TESTING
//  1. Reset mid-stream: 5 entries queued, rst_n=0 async -> count=0, empty=1, mem_valid=0 within same cycle.
//  2. Fill to full: 16 allocs, no fills -> full=1, alloc_ready=0, alloc_idx=0 (wrapped), count=16.
//  3. In-order issue: alloc store idx0, load idx1; fill idx1 then idx0 (addr 0x100,data 0xDEAD) ->
//     mem_valid only after idx0 fill; first handshake we=1 addr 0x100 wdata 0xDEAD, then load idx1.
//  4. Backpressure: head ready, mem_ready=0 for 3 cycles -> mem_valid stays 1, payload stable, count unchanged.
//  5. Wrap + simultaneous: full queue, alloc_valid & deq same cycle -> deq only, count 16->15;
//     next cycle alloc granted idx=old head; head/tail wrap past 15->0 correctly over 40 ops.
//  6. Flush with alloc_valid, ex_valid, mem handshake in same cycle -> next cycle empty=1, head=tail=0.

Source files
------------

// File: rtl/lsq_ring_pkg.sv
// Shared definitions for the circular load/store queue: opcodes, entry flags and index sizing.
package lsq_ring_pkg;

    localparam logic [6:0] LOAD_INSTR  = 7'b0000011;
    localparam logic [6:0] STORE_INSTR = 7'b0100011;

    typedef struct packed {
        logic valid;
        logic is_load;
        logic rdy;
    } lsq_flags_t;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/lsq_ring.sv
// Circular load/store queue: in-order allocation at dispatch, out-of-order operand fill,
// in-order issue of the head entry over a valid/ready memory handshake.
module lsq_ring
    import lsq_ring_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PC_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W     = idx_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  alloc_valid,
    input  logic [6:0]            alloc_opcode,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_idx,
    input  logic                  ex_valid,
    input  logic [IDX_W-1:0]      ex_idx,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [PC_WIDTH-1:0]   mem_pc,
    output logic [IDX_W-1:0]      mem_idx,
    output logic [IDX_W:0]        count,
    output logic                  full,
    output logic                  empty
);

    typedef struct packed {
        lsq_flags_t            f;
        logic [PC_WIDTH-1:0]   pc;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } lsq_entry_t;

    lsq_entry_t           q [DEPTH];
    logic [IDX_W-1:0]     head, tail;
    logic [IDX_W:0]       cnt;
    logic                 op_legal, fire, deq, fill_ok;

    assign op_legal = (alloc_opcode == LOAD_INSTR) || (alloc_opcode == STORE_INSTR);
    assign fire     = alloc_valid && alloc_ready && op_legal;
    assign deq      = mem_valid && mem_ready;
    assign fill_ok  = ex_valid && q[ex_idx].f.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) q[i].f <= '0;
        end else begin
            if (fill_ok) begin
                q[ex_idx].addr  <= ex_addr;
                q[ex_idx].data  <= ex_data;
                q[ex_idx].f.rdy <= 1'b1;
            end
            // Dequeue clears after the fill so a retiring head never keeps a stale rdy.
            if (deq) begin
                q[head].f <= '0;
                head      <= head + 1'b1;
            end
            if (fire) begin
                q[tail].f  <= '{valid: 1'b1, is_load: (alloc_opcode == LOAD_INSTR), rdy: 1'b0};
                q[tail].pc <= alloc_pc;
                tail       <= tail + 1'b1;
            end
            cnt <= cnt + (IDX_W+1)'(fire) - (IDX_W+1)'(deq);
        end
    end

    always_comb begin
        count       = cnt;
        full        = (cnt == (IDX_W+1)'(DEPTH));
        empty       = (cnt == '0);
        alloc_ready = !full;
        alloc_idx   = tail;
        mem_valid   = q[head].f.valid && q[head].f.rdy;
        mem_we      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_pc      = '0;
        mem_idx     = '0;
        if (mem_valid) begin
            mem_we    = !q[head].f.is_load;
            mem_addr  = q[head].addr;
            mem_wdata = q[head].data;
            mem_pc    = q[head].pc;
            mem_idx   = head;
        end
    end

    a_opcode_legal: assert property (@(posedge clk) disable iff (!rst_n || flush)
        alloc_valid |-> op_legal);
    a_fill_target_valid: assert property (@(posedge clk) disable iff (!rst_n || flush)
        ex_valid |-> q[ex_idx].f.valid);

endmodule

// File: tb/tb_lsq_ring.sv
// Bench for lsq_ring: occupancy/slot reference model checked every cycle, plus directed scenarios.
module tb_lsq_ring;
    import lsq_ring_pkg::*;

    localparam int DEPTH = 16;
    localparam int PCW   = 12;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          alloc_valid = 1'b0;
    logic [6:0]    alloc_opcode = STORE_INSTR;
    logic [PCW-1:0] alloc_pc = '0;
    logic          alloc_ready;
    logic [IW-1:0] alloc_idx;
    logic          ex_valid = 1'b0;
    logic [IW-1:0] ex_idx = '0;
    logic [AW-1:0] ex_addr = '0;
    logic [DW-1:0] ex_data = '0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [PCW-1:0] mem_pc;
    logic [IW-1:0] mem_idx;
    logic [IW:0]   count;
    logic          full, empty;

    lsq_ring #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_addr(ex_addr), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_idx(mem_idx),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a ring of slots plus head position and occupancy.
    bit             m_valid [DEPTH];
    bit             m_load  [DEPTH];
    bit             m_rdy   [DEPTH];
    logic [PCW-1:0] m_pc    [DEPTH];
    logic [AW-1:0]  m_addr  [DEPTH];
    logic [DW-1:0]  m_data  [DEPTH];
    int             m_head = 0;
    int             m_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit mv, deq, fire;
        int slot;
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] <= 1'b0;
                m_rdy[i]   <= 1'b0;
            end
            m_head <= 0;
            m_cnt  <= 0;
        end else begin
            mv   = m_valid[m_head] && m_rdy[m_head];
            deq  = mv && mem_ready;
            fire = alloc_valid && (m_cnt < DEPTH);
            if (ex_valid && m_valid[ex_idx]) begin
                m_addr[ex_idx] <= ex_addr;
                m_data[ex_idx] <= ex_data;
                m_rdy[ex_idx]  <= 1'b1;
            end
            if (deq) begin
                m_valid[m_head] <= 1'b0;
                m_rdy[m_head]   <= 1'b0;
                m_head          <= (m_head + 1) % DEPTH;
            end
            if (fire) begin
                slot = (m_head + m_cnt) % DEPTH;
                m_valid[slot] <= 1'b1;
                m_load[slot]  <= (alloc_opcode == LOAD_INSTR);
                m_rdy[slot]   <= 1'b0;
                m_pc[slot]    <= alloc_pc;
            end
            m_cnt <= m_cnt + int'(fire) - int'(deq);
        end
    end

    always @(negedge clk) begin : compare
        bit emv;
        emv = m_valid[m_head] && m_rdy[m_head];
        chk("count", 64'(count), 64'(m_cnt));
        chk("full", 64'(full), 64'(m_cnt == DEPTH));
        chk("empty", 64'(empty), 64'(m_cnt == 0));
        chk("alloc_ready", 64'(alloc_ready), 64'(m_cnt < DEPTH));
        chk("alloc_idx", 64'(alloc_idx), 64'((m_head + m_cnt) % DEPTH));
        chk("mem_valid", 64'(mem_valid), 64'(emv));
        chk("mem_we", 64'(mem_we), emv ? 64'(!m_load[m_head]) : 64'(0));
        chk("mem_addr", 64'(mem_addr), emv ? 64'(m_addr[m_head]) : 64'(0));
        chk("mem_wdata", 64'(mem_wdata), emv ? 64'(m_data[m_head]) : 64'(0));
        chk("mem_pc", 64'(mem_pc), emv ? 64'(m_pc[m_head]) : 64'(0));
        chk("mem_idx", 64'(mem_idx), emv ? 64'(m_head) : 64'(0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; alloc_valid = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
    endtask

    // Picks a slot that holds an allocated entry still awaiting operands.
    task automatic pick_fill(output bit found, output int slot);
        int cands[$];
        found = 1'b0;
        slot  = 0;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && !m_rdy[i]) cands.push_back(i);
        if (cands.size() > 0) begin
            found = 1'b1;
            slot  = cands[$urandom_range(cands.size() - 1)];
        end
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        bit found;
        int slot;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        chk("rst_alloc_idx", 64'(alloc_idx), 64'(0));

        // Reset mid-stream
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_opcode = STORE_INSTR; alloc_pc = PCW'(i); ex_valid = 1'b0;
            if (i > 0) begin ex_valid = 1'b1; ex_idx = IW'(i - 1); ex_addr = 32'h40 + i; end
            step();
        end
        idle();
        chk("t1_count5", 64'(count), 64'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_count", 64'(count), 64'(0));
        chk("t1_async_empty", 64'(empty), 64'(1));
        chk("t1_async_mem_valid", 64'(mem_valid), 64'(0));
        step();
        rst_n = 1'b1;

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_opcode = LOAD_INSTR; alloc_pc = PCW'(12'h100 + i);
            step();
        end
        chk("t2_full", 64'(full), 64'(1));
        chk("t2_alloc_ready", 64'(alloc_ready), 64'(0));
        chk("t2_alloc_idx", 64'(alloc_idx), 64'(0));
        chk("t2_count", 64'(count), 64'(16));
        step();
        chk("t2_blocked_count", 64'(count), 64'(16));
        idle();
        flush = 1'b1;
        step();
        idle();

        // In-order issue with backpressure
        alloc_valid = 1'b1; alloc_opcode = STORE_INSTR; alloc_pc = 12'h010; step();
        alloc_opcode = LOAD_INSTR; alloc_pc = 12'h011; step();
        alloc_valid = 1'b0;
        ex_valid = 1'b1; ex_idx = 4'd1; ex_addr = 32'h200; ex_data = 32'h0;
        step();
        ex_valid = 1'b0;
        chk("t3_wait_head", 64'(mem_valid), 64'(0));
        ex_valid = 1'b1; ex_idx = 4'd0; ex_addr = 32'h100; ex_data = 32'hDEAD;
        #1 chk("t3_fill_same_cycle", 64'(mem_valid), 64'(0));
        step();
        ex_valid = 1'b0;
        chk("t3_mem_valid", 64'(mem_valid), 64'(1));
        chk("t3_we", 64'(mem_we), 64'(1));
        chk("t3_addr", 64'(mem_addr), 64'h100);
        chk("t3_wdata", 64'(mem_wdata), 64'hDEAD);
        chk("t3_idx", 64'(mem_idx), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_valid", 64'(mem_valid), 64'(1));
            chk("t4_hold_addr", 64'(mem_addr), 64'h100);
            chk("t4_hold_count", 64'(count), 64'(2));
        end
        mem_ready = 1'b1;
        step();
        chk("t3_load_valid", 64'(mem_valid), 64'(1));
        chk("t3_load_we", 64'(mem_we), 64'(0));
        chk("t3_load_addr", 64'(mem_addr), 64'h200);
        chk("t3_load_idx", 64'(mem_idx), 64'(1));
        step();
        mem_ready = 1'b0;
        chk("t3_drained", 64'(empty), 64'(1));

        // Full queue with simultaneous alloc request and dequeue (head now at 2)
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_opcode = (i % 2) ? LOAD_INSTR : STORE_INSTR;
            alloc_pc = PCW'(12'h200 + i);
            ex_valid = (i > 0); ex_idx = IW'((2 + i - 1) % DEPTH);
            ex_addr = 32'h1000 + i; ex_data = 32'hA000 + i;
            step();
        end
        alloc_valid = 1'b0;
        ex_valid = 1'b1; ex_idx = 4'd1; ex_addr = 32'h2000; ex_data = 32'hBEEF;
        step();
        ex_valid = 1'b0;
        chk("t5_full", 64'(full), 64'(1));
        alloc_valid = 1'b1; alloc_opcode = STORE_INSTR; alloc_pc = 12'h3AA; mem_ready = 1'b1;
        step();
        chk("t5_deq_only_count", 64'(count), 64'(15));
        chk("t5_alloc_idx_old_head", 64'(alloc_idx), 64'(2));
        mem_ready = 1'b0;
        step();
        chk("t5_refill_count", 64'(count), 64'(16));

        // Flush colliding with alloc, fill and a handshake
        flush = 1'b1; alloc_valid = 1'b1; ex_valid = 1'b1; ex_idx = 4'd2; mem_ready = 1'b1;
        #1 chk("t6_mem_valid_in_flush", 64'(mem_valid), 64'(1));
        step();
        idle();
        chk("t6_empty", 64'(empty), 64'(1));
        chk("t6_count", 64'(count), 64'(0));
        chk("t6_tail0", 64'(alloc_idx), 64'(0));

        // Randomized traffic, wrapping many times
        for (int c = 0; c < 3000; c++) begin
            flush       = ($urandom_range(63) == 0);
            alloc_valid = ($urandom_range(99) < 55);
            alloc_opcode = $urandom_range(1) ? LOAD_INSTR : STORE_INSTR;
            alloc_pc    = PCW'($urandom);
            pick_fill(found, slot);
            ex_valid    = found && ($urandom_range(99) < 60);
            ex_idx      = IW'(slot);
            ex_addr     = $urandom;
            ex_data     = $urandom;
            mem_ready   = ($urandom_range(99) < 50);
            step();
        end
        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
